compressor_tree: RTL and testbench
==================================

// Module: compressor_tree
// PURPOSE
// - Bit-heap compressor for a 24-column dot matrix (square24 configuration).
// - Column i holds up to 24 dots of weight 2^i. The block sums every dot into one
//   binary result and presents it as 30 single-bit outputs.
// - Sits behind the input shift/capture stage. It is the final reduction of a squarer
//   or multi-operand adder datapath.
// - Internals: a full/half-adder reduction tree, a final carry-propagate adder and one
//   output register stage.
// PARAMETERS
// - None. Geometry is fixed: 24 columns x 24 rows, 30-bit result.
// PORTS
// clk       input   1   rising-edge clock; the only clock
// rst_n     input   1   asynchronous active-low reset
// src0      input   24  dots of column 0 (weight 2^0); bit j = row j
// src1      input   24  dots of column 1 (weight 2^1)
// ...       input   24  src2..src22 follow the same pattern
// src23     input   24  dots of column 23 (weight 2^23)
// dst0      output  1   result bit 0 (LSB)
// ...       output  1   dst1..dst28 = result bits 1..28
// dst29     output  1   result bit 29 (MSB)
// BEHAVIOUR
// - Arithmetic: R = sum over i=0..23 of popcount(src_i) * 2^i, computed modulo 2^30.
//   dst_k = R[k].
// - Maximum R = 24*(2^24-1) = 0x17FFFFE8 < 2^29, so dst29 is always 0. It is still
//   driven from the adder, not tied off.
// - Every dot counts exactly once and all inputs are treated as unsigned. Bit order
//   inside a column is irrelevant.
// - Reduction: any mix of 3:2 / 2:2 counters, ending in a 30-bit adder over at most
//   two rows. Carries move to column i+1.
// - Timing: inputs are sampled combinationally. R is registered on the rising edge of
//   clk. Latency is exactly 1 cycle: inputs stable before edge N give the result on
//   dst after edge N.
// - Throughput: one new operand set per cycle. No handshake, no valid/ready, no stall.
// - Reset: rst_n low clears all dst to 0 immediately, with no clock needed. While
//   rst_n is low, outputs stay 0 regardless of inputs.
// - Reset deassertion: the first rising edge with rst_n high captures the current
//   inputs.
// - Reset mid-operation: the in-flight result is discarded, with no partial update.
// - No internal state other than the 30-bit output register. Each result is a function
//   of one cycle's inputs only.
// - X on any input may propagate to dst. No X on dst is allowed with known inputs.
// TESTING
// - rst_n=0, all src=0xFFFFFF -> all dst=0 asynchronously. Release reset with all
//   src=0 -> dst word 0x00000000 after 1 edge.
// - All src=0xFFFFFF -> one edge later dst word = 0x17FFFFE8 (dst29=0, dst28=1,
//   dst3..dst0 = 1000).
// - Only src5[17]=1 -> dst word 0x00000020 (dst5=1, all others 0). Walk a single
//   dot through every column and row and check dst = 2^i each time.
// - src0=0xFFFFFF only -> 0x00000018. src23=0xFFFFFF only -> 0x0C000000.
//   src23=0xFFFFFF plus src22=0xFFFFFF -> 0x12000000.
// - Back-to-back vectors: change inputs every cycle; dst must track the previous
//   cycle's inputs. Check against a reference-model sum over 10k random vectors.
// - Assert rst_n asynchronously between edges while dst is nonzero -> dst=0 before the
//   next edge. The result resumes correctly one edge after release.

Source files
------------

// File: rtl/compressor_tree.sv
// Bit-heap compressor: sums 24 columns x 24 dots (column i weighs 2^i) into a 30-bit result.
// Latency is 1 cycle through the output register. There is no backpressure: a new operand set is accepted every cycle.
module compressor_tree (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] src0,
  input  logic [23:0] src1,
  input  logic [23:0] src2,
  input  logic [23:0] src3,
  input  logic [23:0] src4,
  input  logic [23:0] src5,
  input  logic [23:0] src6,
  input  logic [23:0] src7,
  input  logic [23:0] src8,
  input  logic [23:0] src9,
  input  logic [23:0] src10,
  input  logic [23:0] src11,
  input  logic [23:0] src12,
  input  logic [23:0] src13,
  input  logic [23:0] src14,
  input  logic [23:0] src15,
  input  logic [23:0] src16,
  input  logic [23:0] src17,
  input  logic [23:0] src18,
  input  logic [23:0] src19,
  input  logic [23:0] src20,
  input  logic [23:0] src21,
  input  logic [23:0] src22,
  input  logic [23:0] src23,
  output logic        dst0,
  output logic        dst1,
  output logic        dst2,
  output logic        dst3,
  output logic        dst4,
  output logic        dst5,
  output logic        dst6,
  output logic        dst7,
  output logic        dst8,
  output logic        dst9,
  output logic        dst10,
  output logic        dst11,
  output logic        dst12,
  output logic        dst13,
  output logic        dst14,
  output logic        dst15,
  output logic        dst16,
  output logic        dst17,
  output logic        dst18,
  output logic        dst19,
  output logic        dst20,
  output logic        dst21,
  output logic        dst22,
  output logic        dst23,
  output logic        dst24,
  output logic        dst25,
  output logic        dst26,
  output logic        dst27,
  output logic        dst28,
  output logic        dst29
);

  localparam int NCOL   = 30;
  localparam int STAGES = 10;

  logic [23:0] src [24];
  logic [31:0] heap [NCOL];
  logic [31:0] nh   [NCOL];
  logic [31:0] cy_v [NCOL];
  int          cnt  [NCOL];
  int          nc   [NCOL];
  int          ncy  [NCOL];
  logic [31:0] col;
  int          rem;
  logic        fa_a, fa_b, fa_c;
  logic [29:0] row_a, row_b, sum, r_q;

  assign src[0]  = src0;   assign src[1]  = src1;   assign src[2]  = src2;
  assign src[3]  = src3;   assign src[4]  = src4;   assign src[5]  = src5;
  assign src[6]  = src6;   assign src[7]  = src7;   assign src[8]  = src8;
  assign src[9]  = src9;   assign src[10] = src10;  assign src[11] = src11;
  assign src[12] = src12;  assign src[13] = src13;  assign src[14] = src14;
  assign src[15] = src15;  assign src[16] = src16;  assign src[17] = src17;
  assign src[18] = src18;  assign src[19] = src19;  assign src[20] = src20;
  assign src[21] = src21;  assign src[22] = src22;  assign src[23] = src23;

  // Each column is a packed dot list with a compile-time-known height; every stage
  // replaces groups of three dots with a full adder and passes leftovers through.
  always_comb begin
    col  = '0;
    rem  = 0;
    fa_a = 1'b0;
    fa_b = 1'b0;
    fa_c = 1'b0;
    for (int c = 0; c < NCOL; c++) begin
      heap[c] = '0;
      nh[c]   = '0;
      cy_v[c] = '0;
      cnt[c]  = 0;
      nc[c]   = 0;
      ncy[c]  = 0;
    end
    for (int c = 0; c < 24; c++) begin
      heap[c] = {8'b0, src[c]};
      cnt[c]  = 24;
    end
    for (int s = 0; s < STAGES; s++) begin
      for (int c = 0; c < NCOL; c++) begin
        nh[c]   = '0;
        cy_v[c] = '0;
        nc[c]   = 0;
        ncy[c]  = 0;
        col     = heap[c];
        rem     = cnt[c];
        for (int g = 0; g < 11; g++) begin
          if (rem >= 3) begin
            fa_a    = col[0];
            fa_b    = col[1];
            fa_c    = col[2];
            col     = col >> 3;
            rem     = rem - 3;
            nh[c]   = nh[c] | ({31'b0, fa_a ^ fa_b ^ fa_c} << nc[c]);
            nc[c]   = nc[c] + 1;
            cy_v[c] = cy_v[c] | ({31'b0, (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b))} << ncy[c]);
            ncy[c]  = ncy[c] + 1;
          end
        end
        nh[c] = nh[c] | (col << nc[c]);
        nc[c] = nc[c] + rem;
      end
      // Carries from column 29 fall off: the result is taken modulo 2^30.
      for (int c = 1; c < NCOL; c++) begin
        nh[c] = nh[c] | (cy_v[c-1] << nc[c]);
        nc[c] = nc[c] + ncy[c-1];
      end
      for (int c = 0; c < NCOL; c++) begin
        heap[c] = nh[c];
        cnt[c]  = nc[c];
      end
    end
    for (int c = 0; c < NCOL; c++) begin
      row_a[c] = heap[c][0];
      row_b[c] = heap[c][1];
    end
  end

  assign sum = row_a + row_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= sum;
  end

  assign {dst29, dst28, dst27, dst26, dst25, dst24, dst23, dst22, dst21, dst20,
          dst19, dst18, dst17, dst16, dst15, dst14, dst13, dst12, dst11, dst10,
          dst9,  dst8,  dst7,  dst6,  dst5,  dst4,  dst3,  dst2,  dst1,  dst0} = r_q;

endmodule

// File: tb/tb_compressor_tree.sv
// Directed and random checks of compressor_tree against a popcount-weighted sum model.
module tb_compressor_tree;

  logic        clk;
  logic        rst_n;
  logic [23:0] src [24];
  logic [29:0] dst;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    string         name;
    logic [575:0]  srcs;
    logic [29:0]   exp;
  } vec_t;

  vec_t vt [10];

  compressor_tree dut (
    .clk(clk), .rst_n(rst_n),
    .src0(src[0]),   .src1(src[1]),   .src2(src[2]),   .src3(src[3]),
    .src4(src[4]),   .src5(src[5]),   .src6(src[6]),   .src7(src[7]),
    .src8(src[8]),   .src9(src[9]),   .src10(src[10]), .src11(src[11]),
    .src12(src[12]), .src13(src[13]), .src14(src[14]), .src15(src[15]),
    .src16(src[16]), .src17(src[17]), .src18(src[18]), .src19(src[19]),
    .src20(src[20]), .src21(src[21]), .src22(src[22]), .src23(src[23]),
    .dst0(dst[0]),   .dst1(dst[1]),   .dst2(dst[2]),   .dst3(dst[3]),
    .dst4(dst[4]),   .dst5(dst[5]),   .dst6(dst[6]),   .dst7(dst[7]),
    .dst8(dst[8]),   .dst9(dst[9]),   .dst10(dst[10]), .dst11(dst[11]),
    .dst12(dst[12]), .dst13(dst[13]), .dst14(dst[14]), .dst15(dst[15]),
    .dst16(dst[16]), .dst17(dst[17]), .dst18(dst[18]), .dst19(dst[19]),
    .dst20(dst[20]), .dst21(dst[21]), .dst22(dst[22]), .dst23(dst[23]),
    .dst24(dst[24]), .dst25(dst[25]), .dst26(dst[26]), .dst27(dst[27]),
    .dst28(dst[28]), .dst29(dst[29])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] model();
    logic [29:0] r;
    r = '0;
    for (int i = 0; i < 24; i++) r = r + (30'($countones(src[i])) << i);
    return r;
  endfunction

  task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: dst=0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_all(input logic [23:0] v);
    for (int i = 0; i < 24; i++) src[i] = v;
  endtask

  task automatic load(input logic [575:0] p);
    for (int i = 0; i < 24; i++) src[i] = p[i*24 +: 24];
  endtask

  function automatic logic [575:0] col_pat(input int c, input logic [23:0] v);
    logic [575:0] p;
    p = '0;
    p[c*24 +: 24] = v;
    return p;
  endfunction

  initial begin
    logic [29:0] prev, cur;
    logic [575:0] p;

    vt[0] = '{"zero",       '0,                                          30'h00000000};
    vt[1] = '{"all_ones",   '1,                                          30'h17FFFFE8};
    vt[2] = '{"src5_b17",   col_pat(5, 24'h020000),                      30'h00000020};
    vt[3] = '{"src0_full",  col_pat(0, 24'hFFFFFF),                      30'h00000018};
    vt[4] = '{"src23_full", col_pat(23, 24'hFFFFFF),                     30'h0C000000};
    vt[5] = '{"src23_22",   col_pat(23, 24'hFFFFFF) | col_pat(22, 24'hFFFFFF), 30'h12000000};
    vt[6] = '{"alt_aaaa",   {24{24'hAAAAAA}},                            30'h0BFFFFF4};
    vt[7] = '{"src0_src1",  col_pat(0, 24'h800000) | col_pat(1, 24'h000001), 30'h00000003};
    vt[8] = '{"src1_two",   col_pat(1, 24'h000003),                      30'h00000004};
    vt[9] = '{"src12_3dot", col_pat(12, 24'h100101),                     30'h00003000};

    // Reset held low with everything set: outputs must be zero without any clock edge.
    rst_n = 1'b0;
    set_all(24'hFFFFFF);
    #2;
    check("reset_async", dst, 30'h0);
    @(posedge clk); #1;
    check("reset_hold", dst, 30'h0);
    set_all(24'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_zero", dst, 30'h0);

    for (int v = 0; v < 10; v++) begin
      load(vt[v].srcs);
      @(posedge clk); #1;
      check(vt[v].name, dst, vt[v].exp);
    end

    for (int i = 0; i < 24; i++) begin
      for (int j = 0; j < 24; j++) begin
        set_all(24'h0);
        src[i][j] = 1'b1;
        @(posedge clk); #1;
        check("walk_dot", dst, 30'(1) << i);
      end
    end

    // Back-to-back: dst holds last cycle's result until the edge, then the new one.
    set_all(24'h0);
    @(posedge clk); #1;
    prev = 30'h0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 24; i++) begin
        case ($urandom_range(0, 3))
          0:       src[i] = 24'h0;
          1:       src[i] = 24'hFFFFFF;
          default: src[i] = 24'($urandom);
        endcase
      end
      cur = model();
      #1;
      check("hold_prev", dst, prev);
      @(posedge clk); #1;
      check("random", dst, cur);
      prev = cur;
    end

    // Asynchronous reset between edges while the result is nonzero.
    set_all(24'hFFFFFF);
    @(posedge clk); #1;
    check("pre_reset", dst, 30'h17FFFFE8);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset", dst, 30'h0);
    @(posedge clk); #1;
    check("reset_ignores_clk", dst, 30'h0);
    p = col_pat(7, 24'h00000F);
    load(p);
    #2 rst_n = 1'b1;
    #1;
    check("released_no_edge", dst, 30'h0);
    @(posedge clk); #1;
    check("resume", dst, 30'h00000200);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
